// File: rtl/cv32e41s_pmp_arbiter.sv
// Shares one PMP/PMR checker between IF and LSU with round-robin grants, fenced during CSR updates.
// Response one cycle after the grant; a stalled response buffer blocks only its own requester.
package cv32e41s_pkg;

  typedef enum logic [1:0] {
    PRIV_LVL_U = 2'b00,
    PRIV_LVL_S = 2'b01,
    PRIV_LVL_M = 2'b11
  } privlvl_t;

  typedef enum logic [1:0] {
    PMP_ACC_EXEC  = 2'b00,
    PMP_ACC_WRITE = 2'b01,
    PMP_ACC_READ  = 2'b10
  } pmp_req_e;

endpackage

module cv32e41s_pmp_arbiter
  import cv32e41s_pkg::*;
(
  input  logic        clk,
  input  logic        rst,

  input  logic        if_req_valid_i,
  output logic        if_req_ready_o,
  input  logic [33:0] if_req_addr_i,
  input  logic        if_req_debug_region_i,
  input  privlvl_t    if_priv_lvl_i,

  input  logic        lsu_req_valid_i,
  output logic        lsu_req_ready_o,
  input  logic [33:0] lsu_req_addr_i,
  input  logic        lsu_req_debug_region_i,
  input  privlvl_t    lsu_priv_lvl_i,
  input  logic        lsu_req_we_i,

  output logic [33:0] pmp_req_addr_o,
  output pmp_req_e    pmp_req_type_o,
  output logic        pmp_req_debug_region_o,
  output privlvl_t    pmp_priv_lvl_o,
  input  logic        pmp_req_err_i,
  input  logic [33:0] pmr_reloc_addr_i,

  output logic        if_rsp_valid_o,
  input  logic        if_rsp_ready_i,
  output logic        if_rsp_err_o,
  output logic [33:0] if_rsp_addr_o,

  output logic        lsu_rsp_valid_o,
  input  logic        lsu_rsp_ready_i,
  output logic        lsu_rsp_err_o,
  output logic [33:0] lsu_rsp_addr_o,

  input  logic        csr_pmp_busy_i,
  output logic        arb_busy_o
);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    HOLD   = 2'b01,
    SETTLE = 2'b10
  } state_e;

  state_e state_q;
  state_e state_d;
  logic   last_lsu;
  logic   run_ok;
  logic   if_free;
  logic   lsu_free;
  logic   if_elig;
  logic   lsu_elig;
  logic   grant_if;
  logic   grant_lsu;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // SETTLE gives the checker one quiet cycle after the CSRs stop changing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (csr_pmp_busy_i) state_d = HOLD;
      HOLD:    if (!csr_pmp_busy_i) state_d = SETTLE;
      SETTLE:  state_d = csr_pmp_busy_i ? HOLD : RUN;
      default: state_d = RUN;
    endcase
  end

  assign run_ok   = (state_q == RUN) && !csr_pmp_busy_i;
  assign if_free  = !if_rsp_valid_o || if_rsp_ready_i;
  assign lsu_free = !lsu_rsp_valid_o || lsu_rsp_ready_i;
  assign if_elig  = if_req_valid_i && if_free && run_ok;
  assign lsu_elig = lsu_req_valid_i && lsu_free && run_ok;

  assign grant_if  = if_elig && (!lsu_elig || last_lsu);
  assign grant_lsu = lsu_elig && (!if_elig || !last_lsu);

  assign if_req_ready_o  = grant_if;
  assign lsu_req_ready_o = grant_lsu;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_lsu <= 1'b1;
    end else if (grant_if || grant_lsu) begin
      last_lsu <= grant_lsu;
    end
  end

  always_comb begin
    pmp_req_addr_o         = if_req_addr_i;
    pmp_req_type_o         = PMP_ACC_EXEC;
    pmp_req_debug_region_o = if_req_debug_region_i;
    pmp_priv_lvl_o         = if_priv_lvl_i;
    if (grant_lsu) begin
      pmp_req_addr_o         = lsu_req_addr_i;
      pmp_req_type_o         = lsu_req_we_i ? PMP_ACC_WRITE : PMP_ACC_READ;
      pmp_req_debug_region_o = lsu_req_debug_region_i;
      pmp_priv_lvl_o         = lsu_priv_lvl_i;
    end
  end

  // A reload on the same edge as the handshake keeps the buffer full with the new result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rsp_valid_o <= 1'b0;
      if_rsp_err_o   <= 1'b0;
      if_rsp_addr_o  <= 34'd0;
    end else if (grant_if) begin
      if_rsp_valid_o <= 1'b1;
      if_rsp_err_o   <= pmp_req_err_i;
      if_rsp_addr_o  <= pmr_reloc_addr_i;
    end else if (if_rsp_ready_i) begin
      if_rsp_valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lsu_rsp_valid_o <= 1'b0;
      lsu_rsp_err_o   <= 1'b0;
      lsu_rsp_addr_o  <= 34'd0;
    end else if (grant_lsu) begin
      lsu_rsp_valid_o <= 1'b1;
      lsu_rsp_err_o   <= pmp_req_err_i;
      lsu_rsp_addr_o  <= pmr_reloc_addr_i;
    end else if (lsu_rsp_ready_i) begin
      lsu_rsp_valid_o <= 1'b0;
    end
  end

  assign arb_busy_o = if_rsp_valid_o | lsu_rsp_valid_o;

endmodule

// File: tb/tb_cv32e41s_pmp_arbiter.sv
// Random and directed stimulus for the PMP arbiter, checked against a rule-level reference model.
module tb_cv32e41s_pmp_arbiter;
  import cv32e41s_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid_i, if_req_ready_o, if_req_debug_region_i;
  logic [33:0] if_req_addr_i;
  privlvl_t    if_priv_lvl_i;
  logic        lsu_req_valid_i, lsu_req_ready_o, lsu_req_debug_region_i, lsu_req_we_i;
  logic [33:0] lsu_req_addr_i;
  privlvl_t    lsu_priv_lvl_i;
  logic [33:0] pmp_req_addr_o;
  pmp_req_e    pmp_req_type_o;
  logic        pmp_req_debug_region_o;
  privlvl_t    pmp_priv_lvl_o;
  logic        pmp_req_err_i;
  logic [33:0] pmr_reloc_addr_i;
  logic        if_rsp_valid_o, if_rsp_ready_i, if_rsp_err_o;
  logic [33:0] if_rsp_addr_o;
  logic        lsu_rsp_valid_o, lsu_rsp_ready_i, lsu_rsp_err_o;
  logic [33:0] lsu_rsp_addr_o;
  logic        csr_pmp_busy_i, arb_busy_o;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: buffer contents, who was granted last, and the last two busy samples.
  logic        m_if_v, m_if_err, m_lsu_v, m_lsu_err;
  logic [33:0] m_if_addr, m_lsu_addr;
  logic        m_last_was_lsu;
  logic        m_busy_1, m_busy_2;

  logic        obs_g_if, obs_g_lsu;
  pmp_req_e    obs_type;

  cv32e41s_pmp_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req_valid_i(if_req_valid_i), .if_req_ready_o(if_req_ready_o),
    .if_req_addr_i(if_req_addr_i), .if_req_debug_region_i(if_req_debug_region_i),
    .if_priv_lvl_i(if_priv_lvl_i),
    .lsu_req_valid_i(lsu_req_valid_i), .lsu_req_ready_o(lsu_req_ready_o),
    .lsu_req_addr_i(lsu_req_addr_i), .lsu_req_debug_region_i(lsu_req_debug_region_i),
    .lsu_priv_lvl_i(lsu_priv_lvl_i), .lsu_req_we_i(lsu_req_we_i),
    .pmp_req_addr_o(pmp_req_addr_o), .pmp_req_type_o(pmp_req_type_o),
    .pmp_req_debug_region_o(pmp_req_debug_region_o), .pmp_priv_lvl_o(pmp_priv_lvl_o),
    .pmp_req_err_i(pmp_req_err_i), .pmr_reloc_addr_i(pmr_reloc_addr_i),
    .if_rsp_valid_o(if_rsp_valid_o), .if_rsp_ready_i(if_rsp_ready_i),
    .if_rsp_err_o(if_rsp_err_o), .if_rsp_addr_o(if_rsp_addr_o),
    .lsu_rsp_valid_o(lsu_rsp_valid_o), .lsu_rsp_ready_i(lsu_rsp_ready_i),
    .lsu_rsp_err_o(lsu_rsp_err_o), .lsu_rsp_addr_o(lsu_rsp_addr_o),
    .csr_pmp_busy_i(csr_pmp_busy_i), .arb_busy_o(arb_busy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [33:0] rand34();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[33:0];
  endfunction

  function automatic privlvl_t rand_priv();
    case ($urandom_range(2))
      0:       return PRIV_LVL_U;
      1:       return PRIV_LVL_S;
      default: return PRIV_LVL_M;
    endcase
  endfunction

  task automatic model_reset();
    m_if_v = 0; m_if_err = 0; m_if_addr = '0;
    m_lsu_v = 0; m_lsu_err = 0; m_lsu_addr = '0;
    m_last_was_lsu = 1; m_busy_1 = 0; m_busy_2 = 0;
  endtask

  task automatic idle();
    if_req_valid_i = 0; if_req_addr_i = '0; if_req_debug_region_i = 0; if_priv_lvl_i = PRIV_LVL_M;
    lsu_req_valid_i = 0; lsu_req_addr_i = '0; lsu_req_debug_region_i = 0;
    lsu_priv_lvl_i = PRIV_LVL_M; lsu_req_we_i = 0;
    pmp_req_err_i = 0; pmr_reloc_addr_i = '0;
    if_rsp_ready_i = 1; lsu_rsp_ready_i = 1; csr_pmp_busy_i = 0;
  endtask

  // Called at posedge+1 with inputs applied; checks mid-cycle, advances the model, returns at next posedge+1.
  task automatic step();
    logic allowed, e_if, e_lsu, g_if, g_lsu, x_dbg;
    logic [33:0] x_addr;
    pmp_req_e x_type;
    privlvl_t x_priv;
    #3;
    allowed = !csr_pmp_busy_i && !m_busy_1 && !m_busy_2;
    e_if  = if_req_valid_i && (!m_if_v || if_rsp_ready_i) && allowed;
    e_lsu = lsu_req_valid_i && (!m_lsu_v || lsu_rsp_ready_i) && allowed;
    if (e_if && e_lsu) begin
      g_if = m_last_was_lsu; g_lsu = !m_last_was_lsu;
    end else begin
      g_if = e_if; g_lsu = e_lsu;
    end
    if (g_lsu) begin
      x_addr = lsu_req_addr_i; x_dbg = lsu_req_debug_region_i; x_priv = lsu_priv_lvl_i;
      x_type = lsu_req_we_i ? PMP_ACC_WRITE : PMP_ACC_READ;
    end else begin
      x_addr = if_req_addr_i; x_dbg = if_req_debug_region_i; x_priv = if_priv_lvl_i;
      x_type = PMP_ACC_EXEC;
    end
    n_vec++; if (if_rsp_valid_o !== m_if_v) begin n_err++; $display("FAIL if_rsp_valid got=%0h exp=%0h t=%0t", if_rsp_valid_o, m_if_v, $time); end
    n_vec++; if (if_rsp_err_o !== m_if_err) begin n_err++; $display("FAIL if_rsp_err got=%0h exp=%0h t=%0t", if_rsp_err_o, m_if_err, $time); end
    n_vec++; if (if_rsp_addr_o !== m_if_addr) begin n_err++; $display("FAIL if_rsp_addr got=%0h exp=%0h t=%0t", if_rsp_addr_o, m_if_addr, $time); end
    n_vec++; if (lsu_rsp_valid_o !== m_lsu_v) begin n_err++; $display("FAIL lsu_rsp_valid got=%0h exp=%0h t=%0t", lsu_rsp_valid_o, m_lsu_v, $time); end
    n_vec++; if (lsu_rsp_err_o !== m_lsu_err) begin n_err++; $display("FAIL lsu_rsp_err got=%0h exp=%0h t=%0t", lsu_rsp_err_o, m_lsu_err, $time); end
    n_vec++; if (lsu_rsp_addr_o !== m_lsu_addr) begin n_err++; $display("FAIL lsu_rsp_addr got=%0h exp=%0h t=%0t", lsu_rsp_addr_o, m_lsu_addr, $time); end
    n_vec++; if (arb_busy_o !== (m_if_v | m_lsu_v)) begin n_err++; $display("FAIL arb_busy got=%0h exp=%0h t=%0t", arb_busy_o, m_if_v | m_lsu_v, $time); end
    n_vec++; if (if_req_ready_o !== g_if) begin n_err++; $display("FAIL if_req_ready got=%0h exp=%0h t=%0t", if_req_ready_o, g_if, $time); end
    n_vec++; if (lsu_req_ready_o !== g_lsu) begin n_err++; $display("FAIL lsu_req_ready got=%0h exp=%0h t=%0t", lsu_req_ready_o, g_lsu, $time); end
    n_vec++; if (pmp_req_addr_o !== x_addr) begin n_err++; $display("FAIL pmp_req_addr got=%0h exp=%0h t=%0t", pmp_req_addr_o, x_addr, $time); end
    n_vec++; if (pmp_req_type_o !== x_type) begin n_err++; $display("FAIL pmp_req_type got=%0h exp=%0h t=%0t", pmp_req_type_o, x_type, $time); end
    n_vec++; if (pmp_req_debug_region_o !== x_dbg) begin n_err++; $display("FAIL pmp_req_dbg got=%0h exp=%0h t=%0t", pmp_req_debug_region_o, x_dbg, $time); end
    n_vec++; if (pmp_priv_lvl_o !== x_priv) begin n_err++; $display("FAIL pmp_priv_lvl got=%0h exp=%0h t=%0t", pmp_priv_lvl_o, x_priv, $time); end
    obs_g_if = if_req_ready_o; obs_g_lsu = lsu_req_ready_o; obs_type = pmp_req_type_o;
    if (g_if) begin m_if_v = 1; m_if_err = pmp_req_err_i; m_if_addr = pmr_reloc_addr_i; end
    else if (if_rsp_ready_i) m_if_v = 0;
    if (g_lsu) begin m_lsu_v = 1; m_lsu_err = pmp_req_err_i; m_lsu_addr = pmr_reloc_addr_i; end
    else if (lsu_rsp_ready_i) m_lsu_v = 0;
    if (g_if || g_lsu) m_last_was_lsu = g_lsu;
    m_busy_2 = m_busy_1; m_busy_1 = csr_pmp_busy_i;
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    rst = 1; #1; rst = 0; model_reset();
  endtask

  task automatic test_reset();
    idle(); rst = 1; #2;
    n_vec++; if ({if_rsp_valid_o, lsu_rsp_valid_o, arb_busy_o} !== 3'b000) begin n_err++; $display("FAIL reset_valid got=%b exp=000", {if_rsp_valid_o, lsu_rsp_valid_o, arb_busy_o}); end
    n_vec++; if ({if_rsp_err_o, lsu_rsp_err_o} !== 2'b00) begin n_err++; $display("FAIL reset_err got=%b exp=00", {if_rsp_err_o, lsu_rsp_err_o}); end
    n_vec++; if ({if_rsp_addr_o, lsu_rsp_addr_o} !== 68'd0) begin n_err++; $display("FAIL reset_addr got=%h exp=0", {if_rsp_addr_o, lsu_rsp_addr_o}); end
    n_vec++; if ({if_req_ready_o, lsu_req_ready_o} !== 2'b00) begin n_err++; $display("FAIL reset_ready got=%b exp=00", {if_req_ready_o, lsu_req_ready_o}); end
    @(posedge clk); #1; rst = 0; model_reset();
    step();
  endtask

  task automatic test_single_if();
    idle();
    if_req_valid_i = 1; if_req_addr_i = 34'h0_0000_1000; pmp_req_err_i = 0; pmr_reloc_addr_i = 34'h0_0000_2000;
    step();
    n_vec++; if (obs_g_if !== 1'b1) begin n_err++; $display("FAIL single_if_grant got=%0h exp=1", obs_g_if); end
    n_vec++; if (if_rsp_valid_o !== 1'b1 || if_rsp_err_o !== 1'b0 || if_rsp_addr_o !== 34'h0_0000_2000) begin
      n_err++; $display("FAIL single_if_rsp got v=%0h e=%0h a=%0h exp v=1 e=0 a=2000", if_rsp_valid_o, if_rsp_err_o, if_rsp_addr_o);
    end
    idle(); step();
  endtask

  task automatic test_alternate();
    logic [3:0] pat;
    int rsp_cnt;
    pulse_reset(); idle();
    if_req_valid_i = 1; lsu_req_valid_i = 1; rsp_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if_req_addr_i = rand34(); lsu_req_addr_i = rand34(); pmr_reloc_addr_i = rand34();
      step();
      pat[i] = obs_g_lsu;
      rsp_cnt += int'(if_rsp_valid_o) + int'(lsu_rsp_valid_o);
    end
    n_vec++; if (pat !== 4'b1010) begin n_err++; $display("FAIL alternate_pattern got=%b exp=1010 (bit i = LSU won cycle i)", pat); end
    n_vec++; if (rsp_cnt != 4) begin n_err++; $display("FAIL alternate_rsp_count got=%0d exp=4", rsp_cnt); end
    idle(); step();
  endtask

  task automatic test_backpressure();
    int lsu_grants, if_after;
    logic [33:0] held;
    pulse_reset(); idle();
    if_req_valid_i = 1; lsu_req_valid_i = 1; lsu_req_we_i = 1; lsu_rsp_ready_i = 0;
    lsu_grants = 0; if_after = 0; held = '0;
    for (int i = 0; i < 7; i++) begin
      pmr_reloc_addr_i = rand34(); pmp_req_err_i = 1'($urandom_range(1));
      step();
      if (obs_g_lsu) begin
        lsu_grants++; held = lsu_rsp_addr_o;
        n_vec++; if (obs_type !== PMP_ACC_WRITE) begin n_err++; $display("FAIL bp_store_type got=%0h exp=%0h", obs_type, PMP_ACC_WRITE); end
      end else if (lsu_grants > 0) begin
        if (obs_g_if) if_after++;
        n_vec++; if (lsu_rsp_addr_o !== held) begin n_err++; $display("FAIL bp_lsu_hold got=%0h exp=%0h", lsu_rsp_addr_o, held); end
      end
    end
    n_vec++; if (lsu_grants != 1) begin n_err++; $display("FAIL bp_lsu_grants got=%0d exp=1", lsu_grants); end
    n_vec++; if (if_after != 5) begin n_err++; $display("FAIL bp_if_stream got=%0d exp=5", if_after); end
    idle(); step();
  endtask

  task automatic test_back_to_back();
    logic [33:0] r;
    pulse_reset(); idle();
    if_req_valid_i = 1;
    for (int i = 0; i < 4; i++) begin
      r = rand34(); pmr_reloc_addr_i = r;
      step();
      n_vec++; if (if_rsp_valid_o !== 1'b1 || if_rsp_addr_o !== r) begin
        n_err++; $display("FAIL b2b_rsp got v=%0h a=%0h exp v=1 a=%0h", if_rsp_valid_o, if_rsp_addr_o, r);
      end
    end
    idle(); step();
  endtask

  task automatic test_busy_fence();
    logic [5:0] grants;
    pulse_reset(); idle();
    if_req_valid_i = 1; lsu_req_valid_i = 1;
    for (int i = 0; i < 6; i++) begin
      csr_pmp_busy_i = (i < 3);
      step();
      grants[i] = obs_g_if | obs_g_lsu;
      if (i == 5) begin
        n_vec++; if (obs_g_if !== 1'b1) begin n_err++; $display("FAIL fence_first_winner got if=%0h exp if=1", obs_g_if); end
      end
    end
    n_vec++; if (grants !== 6'b100000) begin n_err++; $display("FAIL fence_grants got=%b exp=100000", grants); end
    idle(); step();
  endtask

  task automatic test_reset_mid();
    pulse_reset(); idle();
    if_req_valid_i = 1; lsu_req_valid_i = 1; if_rsp_ready_i = 0; lsu_rsp_ready_i = 0;
    pmr_reloc_addr_i = rand34(); step();
    pmr_reloc_addr_i = rand34(); step();
    n_vec++; if ({if_rsp_valid_o, lsu_rsp_valid_o} !== 2'b11) begin n_err++; $display("FAIL rstmid_full got=%b exp=11", {if_rsp_valid_o, lsu_rsp_valid_o}); end
    rst = 1; #1;
    n_vec++; if ({if_rsp_valid_o, lsu_rsp_valid_o, arb_busy_o} !== 3'b000) begin n_err++; $display("FAIL rstmid_async got=%b exp=000", {if_rsp_valid_o, lsu_rsp_valid_o, arb_busy_o}); end
    #1; rst = 0; model_reset();
    if_rsp_ready_i = 1; lsu_rsp_ready_i = 1;
    step();
    n_vec++; if (obs_g_if !== 1'b1 || obs_g_lsu !== 1'b0) begin n_err++; $display("FAIL rstmid_tie got if=%0h lsu=%0h exp if=1 lsu=0", obs_g_if, obs_g_lsu); end
    idle(); step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      if_req_valid_i = ($urandom_range(9) < 7); lsu_req_valid_i = ($urandom_range(9) < 7);
      if_req_addr_i = rand34(); lsu_req_addr_i = rand34();
      if_req_debug_region_i = 1'($urandom_range(1)); lsu_req_debug_region_i = 1'($urandom_range(1));
      if_priv_lvl_i = rand_priv(); lsu_priv_lvl_i = rand_priv();
      lsu_req_we_i = 1'($urandom_range(1));
      pmp_req_err_i = 1'($urandom_range(1)); pmr_reloc_addr_i = rand34();
      if_rsp_ready_i = ($urandom_range(9) < 7); lsu_rsp_ready_i = ($urandom_range(9) < 7);
      csr_pmp_busy_i = ($urandom_range(19) == 0);
      step();
    end
    idle(); step();
  endtask

  initial begin
    rst = 1; idle(); model_reset();
    obs_g_if = 0; obs_g_lsu = 0; obs_type = PMP_ACC_EXEC;
    test_reset();
    test_single_if();
    test_alternate();
    test_backpressure();
    test_back_to_back();
    test_busy_fence();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
